// File: rtl/pipe_exe_md_stage_pkg.sv
// Shared types for the execute stage: opcode and MD sequencer encodings.
package pipe_exe_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU  = 5'd3,
    OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR   = 5'd7,
    OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_SLL  = 5'd10, OP_SRL   = 5'd11,
    OP_SRA  = 5'd12, OP_LUI  = 5'd13, OP_MFHI = 5'd14, OP_MFLO  = 5'd15,
    OP_MTHI = 5'd16, OP_MTLO = 5'd17, OP_MULT = 5'd18, OP_MULTU = 5'd19,
    OP_DIV  = 5'd20, OP_DIVU = 5'd21
  } op_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_e;

  localparam int DATA_W_DFLT = 32;

  function automatic int shamt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int SHAMT_W = shamt_w(DATA_W_DFLT);

endpackage

// File: rtl/pipe_exe_md_stage_md_iter.sv
// Iterative multiply/divide core: one radix-2 step per cycle on operand
// magnitudes, with signs and the divide-by-zero case resolved on the outputs.
module md_iter_unit
  import pipe_exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  op_e                 opc;
  logic                sign_op, start_div, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                running, is_div, neg_q, neg_r, div0;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi_r, lo_r, dvs, dvd;
  logic [DATA_W:0]     add_w, trial;
  logic [DATA_W-1:0]   hi_n, lo_n;
  logic [2*DATA_W-1:0] prod, prod_neg;

  assign opc       = op_e'(op);
  assign sign_op   = (opc == OP_MULT) || (opc == OP_DIV);
  assign start_div = (opc == OP_DIV) || (opc == OP_DIVU);
  assign a_neg     = sign_op && a[DATA_W-1];
  assign b_neg     = sign_op && b[DATA_W-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign done      = running && (cnt == CNT_W'(DATA_W-1));

  // hi_r doubles as product-high / partial remainder, lo_r as multiplier / quotient
  always_comb begin
    add_w = {1'b0, hi_r} + (lo_r[0] ? {1'b0, dvs} : '0);
    trial = {hi_r, lo_r[DATA_W-1]} - {1'b0, dvs};
    if (is_div) begin
      if (!trial[DATA_W]) begin
        hi_n = trial[DATA_W-1:0];
        lo_n = {lo_r[DATA_W-2:0], 1'b1};
      end else begin
        hi_n = {hi_r[DATA_W-2:0], lo_r[DATA_W-1]};
        lo_n = {lo_r[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_n = add_w[DATA_W:1];
      lo_n = {add_w[0], lo_r[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      dvs     <= '0;
      dvd     <= '0;
    end else if (kill) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      is_div  <= start_div;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      div0    <= start_div && (b == '0);
      dvd     <= a;
      hi_r    <= '0;
      dvs     <= start_div ? b_mag : a_mag;
      lo_r    <= start_div ? a_mag : b_mag;
    end else if (running) begin
      hi_r <= hi_n;
      lo_r <= lo_n;
      cnt  <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  assign prod     = {hi_r, lo_r};
  assign prod_neg = -prod;

  // Remainder follows the dividend's sign; quotient negates when signs differ
  always_comb begin
    if (!is_div) begin
      {hi, lo} = neg_q ? prod_neg : prod;
    end else if (div0) begin
      lo = '1;
      hi = dvd;
    end else begin
      lo = neg_q ? -lo_r : lo_r;
      hi = neg_r ? -hi_r : hi_r;
    end
  end

endmodule

// File: rtl/pipe_exe_md_stage.sv
// Execute stage: single-cycle ALU, HI/LO and an iterative MD unit feeding a
// registered EXE/MEM slot with valid/ready backpressure.
module pipe_exe_md_stage
  import pipe_exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_op,
  input  logic               in_a_sel,
  input  logic               in_b_sel,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic [DATA_W-1:0]  in_rt,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [DATA_W-1:0]  in_shamt,
  input  logic [DATA_W-1:0]  in_pc4,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic               in_wen,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [DATA_W-1:0]  out_pc4,
  output logic [DATA_W-1:0]  out_rt,
  output logic [RADDR_W-1:0] out_waddr,
  output logic               out_wen,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               out_ovf,
  output logic               busy
);

  localparam int SH_W = shamt_w(DATA_W);
  localparam int MSB  = DATA_W - 1;

  md_state_e          state;
  op_e                op;
  logic [DATA_W-1:0]  a, b, sum, diff, alu_res;
  logic [SH_W-1:0]    sh;
  logic               alu_ovf, wr_ok, wen_eff, hi_we, lo_we, is_md;
  logic               slot_free, accept, load_alu, load_md;
  logic [DATA_W-1:0]  hi_q, lo_q;
  logic               md_done;
  logic [DATA_W-1:0]  md_hi, md_lo;
  logic [DATA_W-1:0]  md_pc4, md_rt;
  logic [RADDR_W-1:0] md_waddr;
  logic [CTRL_W-1:0]  md_ctrl;

  assign op        = op_e'(in_op);
  assign a         = in_a_sel ? in_rs : in_shamt;
  assign b         = in_b_sel ? in_imm : in_rt;
  assign sh        = a[SH_W-1:0];
  assign sum       = a + b;
  assign diff      = a - b;
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && slot_free && !flush;
  assign accept    = in_valid && in_ready;
  assign load_alu  = accept && !is_md;
  assign load_md   = (state == DONE) && slot_free;
  assign busy      = (state != IDLE);
  assign wen_eff   = wr_ok && !alu_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    wr_ok   = in_wen;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    is_md   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, a < b};
      OP_SLL:  alu_res = b << sh;
      OP_SRL:  alu_res = b >> sh;
      OP_SRA:  alu_res = $signed(b) >>> sh;
      OP_LUI:  alu_res = b << (DATA_W/2);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MTHI: begin hi_we = 1'b1; wr_ok = 1'b0; end
      OP_MTLO: begin lo_we = 1'b1; wr_ok = 1'b0; end
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin is_md = 1'b1; wr_ok = 1'b0; end
      default: wr_ok = 1'b0;
    endcase
  end

  md_iter_unit #(.DATA_W(DATA_W)) u_md (
    .clk   (clk),
    .rst   (rst),
    .kill  (flush),
    .start (accept && is_md),
    .op    (in_op),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // Flush kills the slot and the MD op but leaves HI/LO alone
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_pc4    <= '0;
      out_rt     <= '0;
      out_waddr  <= '0;
      out_wen    <= 1'b0;
      out_ctrl   <= '0;
      out_ovf    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      md_pc4     <= '0;
      md_rt      <= '0;
      md_waddr   <= '0;
      md_ctrl    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end else begin
      if (slot_free) out_valid <= load_alu || load_md;
      if (load_alu) begin
        out_result <= alu_res;
        out_ovf    <= alu_ovf;
        out_wen    <= wen_eff;
        out_pc4    <= in_pc4;
        out_rt     <= in_rt;
        out_waddr  <= in_waddr;
        out_ctrl   <= in_ctrl;
      end
      if (load_md) begin
        out_result <= md_lo;
        out_ovf    <= 1'b0;
        out_wen    <= 1'b0;
        out_pc4    <= md_pc4;
        out_rt     <= md_rt;
        out_waddr  <= md_waddr;
        out_ctrl   <= md_ctrl;
        hi_q       <= md_hi;
        lo_q       <= md_lo;
      end
      if (accept && hi_we) hi_q <= in_rs;
      if (accept && lo_we) lo_q <= in_rs;
      if (accept && is_md) begin
        md_pc4   <= in_pc4;
        md_rt    <= in_rt;
        md_waddr <= in_waddr;
        md_ctrl  <= in_ctrl;
      end
      case (state)
        IDLE:    if (accept && is_md) state <= RUN;
        RUN:     if (md_done) state <= DONE;
        DONE:    if (slot_free) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipe_exe_md_stage.md
Name: pipe_exe_md_stage

Overview:
- Parametrised execute stage for the static pipeline.
- Combines the single-cycle ALU path with an iterative multiply/divide unit and internal HI/LO registers.
- Owns the registered EXE/MEM boundary, using a valid/ready handshake so MUL/DIV can stall upstream.
- Sits between the ID/EXE register and the memory stage; operand muxing (shamt/rs, rt/imm) is internal.

Parameters:
- DATA_W, 32: datapath width; even, ≥8.
- RADDR_W, 5: register-file write-address width.
- CTRL_W, 8: opaque sideband (DMEM/RF-mux controls) carried unchanged to the output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill in-flight op and output slot
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_op  in  5  operation code (pkg enum)
- in_a_sel  in  1  0=shamt, 1=rs
- in_b_sel  in  1  0=rt, 1=imm
- in_rs, in_rt, in_imm, in_shamt  in  DATA_W  operands
- in_pc4  in  DATA_W  PC+4 passthrough
- in_waddr  in  RADDR_W  RF write address
- in_wen  in  1  RF write enable
- in_ctrl  in  CTRL_W  sideband
- out_valid  out  1  output slot valid
- out_ready  in  1  memory stage accepts
- out_result, out_pc4, out_rt  out  DATA_W  registered result, PC+4 and store data
- out_waddr  out  RADDR_W  registered write address
- out_wen  out  1  registered write enable
- out_ctrl  out  CTRL_W  registered sideband
- out_ovf  out  1  signed overflow on ADD/SUB
- busy  out  1  MD FSM not IDLE

Behaviour:
- Reset: all out_* = 0, out_valid = 0, HI = LO = 0, FSM = IDLE, busy = 0.
- slot_free = !out_valid || out_ready.
- in_ready = (state==IDLE) && slot_free && !flush.
- Operand selection: a = in_a_sel ? rs : shamt; b = in_b_sel ? imm : rt.
- ALU ops (ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI): 1-cycle latency. When accepted, the output slot loads on the next edge.
- Shift amount = a[log2(DATA_W)-1:0]. LUI = b << DATA_W/2.
- ADD/SUB signed overflow: out_ovf = 1 and out_wen forced 0. ADDU/SUBU never set out_ovf.
- MFHI/MFLO: 1 cycle, result = HI/LO. MTHI/MTLO: 1 cycle, write HI/LO from rs at acceptance, output slot loaded with wen = 0.
- MULT/MULTU/DIV/DIVU use the FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE -> RUN on accept; the operation latches its operands.
  - RUN takes exactly DATA_W cycles: radix-2 shift-add multiply, or restoring divide on magnitudes with the sign fixed at the end.
  - RUN -> DONE after the last iteration.
  - DONE: when slot_free, write HI/LO, load the output slot (result = LO, wen = 0), go to IDLE. Otherwise hold in DONE.
  - Minimum accept-to-out_valid latency is DATA_W+1 cycles.
- Multiply: {HI, LO} = 2·DATA_W-bit product, signed or unsigned per op.
- Divide: LO = quotient, HI = remainder; remainder takes the dividend's sign.
- Divide by zero: LO = all-ones, HI = dividend.
- DIV of MIN / -1: LO = MIN, HI = 0.
- An op following an MD op sees the updated HI/LO, because in_ready stays low until DONE resolves.
- Flush (same edge): out_valid <- 0, FSM <- IDLE, HI/LO unchanged, and no accept that cycle. Flush takes priority over in_valid, DONE writeback and reset-free holds. rst takes priority over flush.
- Output hold: when out_valid && !out_ready, every out_* holds stable.
- Back-to-back ALU ops with out_ready = 1 sustain 1 op/cycle.
- Undefined in_op codes are treated as a NOP: slot loaded, wen = 0, result = 0.

Decomposition:
- Package pipe_exe_pkg holds:
  - op_e enum, 5-bit, with the ops above;
  - md_state_e enum {IDLE, RUN, DONE};
  - helper constant SHAMT_W = $clog2(DATA_W).
- Sub-module md_iter_unit, parametrised by DATA_W:
  - inputs: start, op, a, b;
  - outputs: done, hi, lo;
  - contains the cycle counter and shift registers.
- The top level holds the ALU, HI/LO, the FSM glue and the output register.

Test Plan:
- ADD 0x7FFFFFFF + 1 (rs/rt path), out_ready = 1 -> next cycle out_valid = 1, out_result = 0x80000000, out_ovf = 1, out_wen = 0. Then ADDU with the same operands -> out_ovf = 0, out_wen = 1.
- MULT rs = -3, rt = 7, then MFHI, MFLO -> in_ready low for 33 cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, and the MFHI/MFLO results match. MULTU 0xFFFFFFFF² -> HI = 0xFFFFFFFE, LO = 1.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- Backpressure: out_ready = 0 for 5 cycles with out_valid = 1 -> outputs stable, in_ready = 0. An MD op finishing during the stall holds in DONE, then drains on the first cycle out_ready = 1.
- Flush at RUN cycle 10 of DIV with HI = 0x11 -> busy = 0 next cycle, out_valid = 0, HI still 0x11, and a new op is accepted the following cycle.
- SLL shamt = 4, rt = 0x0000000F (a_sel = 0) -> 0x000000F0. SRA shamt = 31, rt = 0x80000000 -> 0xFFFFFFFF. LUI imm = 0x1234 -> 0x12340000. Sideband and pc4 pass through unchanged.
